// File: rtl/bitrev_reorder.sv
// Reorders one frame of 2^N FFT samples from bit-reversed to natural order.
// Latency: first output 1 cycle after the frame's last input is accepted (read side idle).
// Backpressure: in_ready drops when the write bank is full; out_data/out_last hold while out_valid && !out_ready.
//
// Ports:
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready     write handshake, in_data arrives in bit-reversed order
//   out_valid/out_ready   read handshake, out_data leaves in natural order
//   out_last              marks sample 2^N-1 of each output frame
//
// Build option: define BITREV_REORDER_PINGPONG_EN for two frame banks (write of
// frame k+1 overlaps read of frame k). Without it a single bank is used and the
// writer waits for the reader to drain each frame.
module bitrev_reorder #(
    parameter int N  = 3,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_last
);

`ifdef BITREV_REORDER_PINGPONG_EN
    localparam int B = 2;
`else
    localparam int B = 1;
`endif
    // Memory address is {bank, sample} with two banks, plain sample with one.
    localparam int AW = (B == 2) ? N + 1 : N;
    localparam logic [N-1:0] CNT_MAX = '1;

    logic [DW-1:0] mem [2**AW];

    logic [N-1:0]  wr_cnt;
    logic [N-1:0]  rd_cnt;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;
    logic          wr_full;
    logic          rd_full;
    logic          wr_fire;
    logic          wr_done;
    logic          load;
    logic          rd_done;

    // Mirror the N index bits: bit i takes bit N-1-i.
    function automatic logic [N-1:0] rev(input logic [N-1:0] v);
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) begin
            r[i] = v[N-1-i];
        end
        return r;
    endfunction

`ifdef BITREV_REORDER_PINGPONG_EN
    logic       wb;
    logic       rb;
    logic [1:0] full;

    assign wr_full = full[wb];
    assign rd_full = full[rb];
    assign wr_addr = {wb, rev(wr_cnt)};
    assign rd_addr = {rb, rd_cnt};

    // A completing write and a completing read always hit different banks:
    // the write bank is empty by construction, the read bank is full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb   <= 1'b0;
            rb   <= 1'b0;
            full <= '0;
        end else begin
            if (wr_done) begin
                full[wb] <= 1'b1;
                wb       <= ~wb;
            end
            if (rd_done) begin
                full[rb] <= 1'b0;
                rb       <= ~rb;
            end
        end
    end
`else
    logic full;

    assign wr_full = full;
    assign rd_full = full;
    assign wr_addr = rev(wr_cnt);
    assign rd_addr = rd_cnt;

    // With one bank, writes need !full and reads need full, so the two
    // completion events are mutually exclusive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= 1'b0;
        end else if (wr_done) begin
            full <= 1'b1;
        end else if (rd_done) begin
            full <= 1'b0;
        end
    end
`endif

    // in_ready comes only from registered bank state.
    assign in_ready = !wr_full;
    assign wr_fire  = in_valid && in_ready;
    assign wr_done  = wr_fire && (wr_cnt == CNT_MAX);

    // Load the output register whenever it is empty or being emptied this cycle,
    // which keeps 1 sample/cycle across frame boundaries.
    assign load    = rd_full && (!out_valid || out_ready);
    assign rd_done = load && (rd_cnt == CNT_MAX);

    // Sample storage carries no reset; stale contents are never read because
    // a bank is only read after it has been completely rewritten.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_addr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt <= '0;
        end else if (wr_fire) begin
            wr_cnt <= wr_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt    <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else if (load) begin
            rd_cnt    <= rd_cnt + 1'b1;
            out_valid <= 1'b1;
            out_last  <= (rd_cnt == CNT_MAX);
            out_data  <= mem[rd_addr];
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

endmodule

// File: doc/bitrev_reorder.md
# bitrev_reorder

Reorder buffer on the output side of the R2SDF FFT pipeline. It accepts one frame of 2^N samples in bit-reversed order (X[rev(0)], X[rev(1)], …) and emits the same frame in natural order (X[0], X[1], …). It is the counterpart to the bit-reversal index generation used on the input side. Both ports use valid/ready handshakes, and two frame buffers allow continuous streaming.

## Interface
- N, 3: log2 of frame length; frame = 2^N samples
- DW, 32: sample width in bits (packed complex re/im, opaque to this block)
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  in_data holds a sample
- in_ready  output  1  block can accept a sample this cycle
- in_data  input  DW  sample, bit-reversed order within frame
- out_valid  output  1  out_data holds a sample
- out_ready  input  1  downstream accepts out_data this cycle
- out_data  output  DW  sample, natural order
- out_last  output  1  out_data is sample 2^N-1 of the frame

## Operation
- Storage: banks B = 2 (ping-pong) or 1 (see Configuration), each 2^N x DW. full[b] flag per bank.
- Write side:
  - wr_cnt (N bits), write bank pointer wb.
  - in_ready = !full[wb] (combinational).
  - On in_valid && in_ready: mem[wb][rev(wr_cnt)] <= in_data; wr_cnt++.
  - rev() mirrors N bits: bit i ← bit N-1-i.
  - Accepting the sample at wr_cnt == 2^N-1: wr_cnt wraps to 0, full[wb] <= 1, wb toggles.
- Read side:
  - rd_cnt (N bits), read bank pointer rb.
  - load = full[rb] && (!out_valid || out_ready).
  - On load: out_data <= mem[rb][rd_cnt]; out_last <= (rd_cnt == 2^N-1); out_valid <= 1; rd_cnt++.
  - A load at rd_cnt == 2^N-1 wraps rd_cnt to 0, sets full[rb] <= 0, and toggles rb.
  - On out_valid && out_ready && !load: out_valid <= 0, out_last <= 0.
- Simultaneous events:
  - A write completing bank A and a read completing bank B in the same cycle both take effect.
  - A write and a read in the same cycle never target the same full bank, because writes require !full[wb].
  - A bank freed by a read is writable from the next cycle.
- Frames carry no explicit start marker. Frame alignment comes solely from wr_cnt since reset.

## Timing
- Reset values:
  - wr_cnt = rd_cnt = 0, wb = rb = 0, full = 0.
  - out_valid = 0, out_last = 0, out_data = 0.
  - in_ready = 1 once rst_n is high.
- Reset asserted mid-frame discards all partial and buffered frames. Memory contents need not be cleared.
- Latency: the first out_valid of a frame rises 1 cycle after the cycle that accepts that frame's last input, provided the read side is idle.
- Throughput with out_ready held high: 1 sample/cycle sustained. out_valid never drops between back-to-back frames.
- out_data and out_last hold stable while out_valid && !out_ready.
- in_ready depends only on registered state, never combinationally on in_valid or out_ready.

## Configuration
- BITREV_REORDER_PINGPONG_EN defined:
  - B = 2; write and read of consecutive frames overlap.
  - in_ready stalls only when both banks are full.
- BITREV_REORDER_PINGPONG_EN undefined:
  - B = 1; wb and rb are fixed at 0.
  - in_ready is low from the cycle after the last write of a frame until the cycle after the final read of that frame.
  - Max throughput is 2^N samples per 2^N+1 … 2·2^N cycles.

## Test plan
- N=3, feed in_data = 0..7 with no stalls and out_ready=1 -> out_data sequence 0,4,2,6,1,5,3,7; out_last only on the 8th output (value 7); first out_valid 1 cycle after input 7 accepted.
- Ping-pong on, two back-to-back frames (0..7, 8..15) with out_ready=1 -> in_ready stays 1 for all 16 inputs; outputs are 0,4,2,6,1,5,3,7,8,12,10,14,9,13,11,15 with no gap.
- Ping-pong on, out_ready=0, stream 24 inputs -> in_ready drops after input 15 is accepted; out_data stable at 0; raising out_ready resumes in order and accepts the third frame.
- Ping-pong off, continuous input with out_ready=1 -> in_ready low for 8 cycles after each frame; output order per frame as above.
- Random out_ready (50%) over 10 frames -> output equals the bit-reversal permutation of input per frame; no loss or duplication; out_last every 8th transfer.
- Assert rst_n low after 5 inputs of a frame, then release and send 0..7 -> all outputs/flags at reset values during reset; output after release is 0,4,2,6,1,5,3,7 with no residue from the aborted frame.
